// File: rtl/z88_pkg.sv
// Shared definitions for the LCD fetch engine: FSM states, attribute bit
// positions, screen geometry and the font bank split codes.
package z88_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTR0,
        ATTR1,
        FONT,
        EMIT
    } lcd_state_e;

    localparam int ATTR_HRS = 5;
    localparam int ATTR_REV = 4;
    localparam int ATTR_FLS = 3;
    localparam int ATTR_GRY = 2;
    localparam int ATTR_UND = 1;
    localparam int ATTR_CH8 = 0;

    localparam logic [9:0] SCREEN_W    = 10'd640;
    localparam logic [8:0] LORES_SPLIT = 9'h1C0;
    localparam logic [9:0] HIRES_SPLIT = 10'h300;

    // Z80 owns the video bus in this phase of the master clock.
    localparam logic [1:0] CLK_Z80 = 2'd2;

endpackage

// File: rtl/lcd_fetch_if.sv
// Video memory read port plus the pixel-cell output stream of the fetcher.
interface lcd_fetch_if;
    logic [21:0] va;
    logic [7:0]  vid_cdo;
    logic        out_valid;
    logic [9:0]  out_x;
    logic [5:0]  out_y;
    logic        out_wide;
    logic [7:0]  out_pix;
    logic        out_ready;
    logic        frame_done;

    modport master (
        output va, out_valid, out_x, out_y, out_wide, out_pix, frame_done,
        input  vid_cdo, out_ready
    );

    modport slave (
        input  va, out_valid, out_x, out_y, out_wide, out_pix, frame_done,
        output vid_cdo, out_ready
    );
endinterface

// File: rtl/lcd_font_addr.sv
// Combinational font address mux: selects the font bank and index from the
// character code, the hires flag and the pixel line within the cell.
module lcd_font_addr
    import z88_pkg::*;
(
    input  logic        hires,
    input  logic [8:0]  code,
    input  logic [2:0]  line,
    input  logic [12:0] pb0,
    input  logic [9:0]  pb1,
    input  logic [8:0]  pb2,
    input  logic [10:0] pb3,
    output logic [21:0] addr
);

    logic [9:0] code_w;
    assign code_w = {1'b0, code};

    always_comb begin
        if (!hires) begin
            addr = (code < LORES_SPLIT) ? {pb1, code, line} : {pb0, code[5:0], line};
        end else begin
            addr = (code_w < HIRES_SPLIT) ? {pb2, code_w, line} : {pb3, code_w[7:0], line};
        end
    end

endmodule

// File: rtl/lcd_fetch.sv
// LCD cell fetcher: reads char/attr/font bytes around Z80 cycles and streams
// one pixel cell per handshake. Define LCD_GREY_EN to enable the grey effect.
module lcd_fetch
    import z88_pkg::*;
(
    input  logic        mck,
    input  logic        res,
    input  logic [1:0]  clkcnt,
    input  logic        lcdon,
    input  logic [12:0] pb0w,
    input  logic [9:0]  pb1w,
    input  logic [8:0]  pb2w,
    input  logic [10:0] pb3w,
    input  logic [10:0] sbrw,
    input  logic        t_1s,
    input  logic        t_5ms,
    lcd_fetch_if.master bus
);

    lcd_state_e  state_q, state_d;
    logic [21:0] va_q, va_d;
    logic [9:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  char_q, char_d;
    logic [5:0]  attr_q, attr_d;
    logic [12:0] pb0_q, pb0_d;
    logic [9:0]  pb1_q, pb1_d;
    logic [8:0]  pb2_q, pb2_d;
    logic [10:0] pb3_q, pb3_d;
    logic [10:0] sbr_q, sbr_d;
    logic        out_valid_q, out_valid_d;
    logic [9:0]  out_x_q, out_x_d;
    logic [5:0]  out_y_q, out_y_d;
    logic        out_wide_q, out_wide_d;
    logic [7:0]  out_pix_q, out_pix_d;
    logic        frame_done_q, frame_done_d;

    logic        hires_c, stall_c, line_end_c, frame_end_c;
    logic [9:0]  nx_c, x_nxt_c;
    logic [6:0]  col_nxt_c;
    logic [5:0]  y_nxt_c;
    logic [7:0]  used_c, pix_c;
    logic [21:0] font_addr_c;

    assign hires_c = attr_q[ATTR_HRS];
    assign stall_c = (clkcnt == CLK_Z80);

    lcd_font_addr u_font_addr (
        .hires (bus.vid_cdo[ATTR_HRS]),
        .code  ({bus.vid_cdo[ATTR_CH8], char_q}),
        .line  (y_q[2:0]),
        .pb0   (pb0_q),
        .pb1   (pb1_q),
        .pb2   (pb2_q),
        .pb3   (pb3_q),
        .addr  (font_addr_c)
    );

    // Position of the cell after the current one, valid once attr_q is loaded.
    always_comb begin
        nx_c        = x_q + (hires_c ? 10'd8 : 10'd6);
        line_end_c  = (nx_c >= SCREEN_W) || (col_q == 7'd127);
        x_nxt_c     = line_end_c ? 10'd0 : nx_c;
        col_nxt_c   = line_end_c ? 7'd0 : col_q + 7'd1;
        y_nxt_c     = line_end_c ? y_q + 6'd1 : y_q;
        frame_end_c = line_end_c && (y_q == 6'd63);
    end

    always_comb begin
        used_c = hires_c ? 8'hFF : 8'hFC;
        pix_c  = hires_c ? bus.vid_cdo : {bus.vid_cdo[5:0], 2'b00};
        if (attr_q[ATTR_UND] && !hires_c && (y_q[2:0] == 3'd7)) pix_c = pix_c | used_c;
        if (attr_q[ATTR_REV]) pix_c = pix_c ^ used_c;
        if (attr_q[ATTR_FLS] && !t_1s) pix_c = 8'h00;
`ifdef LCD_GREY_EN
        if (attr_q[ATTR_GRY] && t_5ms) pix_c = 8'h00;
`endif
    end

`ifndef LCD_GREY_EN
    logic unused_grey;
    assign unused_grey = t_5ms ^ attr_q[ATTR_GRY];
`endif

    always_comb begin
        state_d      = state_q;
        va_d         = va_q;
        x_d          = x_q;
        y_d          = y_q;
        col_d        = col_q;
        char_d       = char_q;
        attr_d       = attr_q;
        pb0_d        = pb0_q;
        pb1_d        = pb1_q;
        pb2_d        = pb2_q;
        pb3_d        = pb3_q;
        sbr_d        = sbr_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_wide_d   = out_wide_q;
        out_pix_d    = out_pix_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (lcdon) begin
                    x_d     = 10'd0;
                    y_d     = 6'd0;
                    col_d   = 7'd0;
                    pb0_d   = pb0w;
                    pb1_d   = pb1w;
                    pb2_d   = pb2w;
                    pb3_d   = pb3w;
                    sbr_d   = sbrw;
                    va_d    = {sbrw, 3'd0, 7'd0, 1'b0};
                    state_d = ATTR0;
                end
            end
            ATTR0: begin
                if (!stall_c) begin
                    char_d  = bus.vid_cdo;
                    va_d    = {sbr_q, y_q[5:3], col_q, 1'b1};
                    state_d = ATTR1;
                end
            end
            ATTR1: begin
                if (!stall_c) begin
                    attr_d  = bus.vid_cdo[5:0];
                    va_d    = font_addr_c;
                    state_d = FONT;
                end
            end
            FONT: begin
                if (!stall_c) begin
                    out_pix_d   = pix_c;
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    out_wide_d  = hires_c;
                    out_valid_d = 1'b1;
                    // Point at the next cell's char byte so va moves only on a capture.
                    va_d        = {sbr_q, y_nxt_c[5:3], col_nxt_c, 1'b0};
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    x_d         = x_nxt_c;
                    col_d       = col_nxt_c;
                    y_d         = y_nxt_c;
                    if (frame_end_c) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = ATTR0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!lcdon) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge mck) begin
        if (res) begin
            state_q      <= IDLE;
            va_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            col_q        <= '0;
            char_q       <= '0;
            attr_q       <= '0;
            pb0_q        <= '0;
            pb1_q        <= '0;
            pb2_q        <= '0;
            pb3_q        <= '0;
            sbr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_wide_q   <= 1'b0;
            out_pix_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            va_q         <= va_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_q        <= col_d;
            char_q       <= char_d;
            attr_q       <= attr_d;
            pb0_q        <= pb0_d;
            pb1_q        <= pb1_d;
            pb2_q        <= pb2_d;
            pb3_q        <= pb3_d;
            sbr_q        <= sbr_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_wide_q   <= out_wide_d;
            out_pix_q    <= out_pix_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.va         = va_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_wide   = out_wide_q;
    assign bus.out_pix    = out_pix_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_fetch.sv
// Directed bench for lcd_fetch: sparse video memory model, transfer and
// address monitors, hand-computed expectations for each cell.
module tb_lcd_fetch;

    logic        mck = 1'b0;
    logic        res;
    logic [1:0]  clkcnt = 2'd0;
    logic        lcdon;
    logic [12:0] pb0w;
    logic [9:0]  pb1w;
    logic [8:0]  pb2w;
    logic [10:0] pb3w;
    logic [10:0] sbrw;
    logic        t_1s;
    logic        t_5ms;

    lcd_fetch_if bus ();

    lcd_fetch dut (
        .mck    (mck),
        .res    (res),
        .clkcnt (clkcnt),
        .lcdon  (lcdon),
        .pb0w   (pb0w),
        .pb1w   (pb1w),
        .pb2w   (pb2w),
        .pb3w   (pb3w),
        .sbrw   (sbrw),
        .t_1s   (t_1s),
        .t_5ms  (t_5ms),
        .bus    (bus)
    );

    always #50 mck = ~mck;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Sparse video memory, unwritten bytes read as zero.
    logic [7:0] mem [int];
    int         mem_gen = 0;
    logic [7:0] rd_v;
    always @(bus.va or mem_gen) begin
        if (mem.exists(int'(bus.va))) rd_v = mem[int'(bus.va)];
        else rd_v = 8'h00;
    end
    assign bus.vid_cdo = rd_v;

    typedef struct packed {
        logic [9:0] x;
        logic [5:0] y;
        logic       wide;
        logic [7:0] pix;
    } xfer_t;

    xfer_t       xq[$];
    logic [21:0] va_log[$];
    int          stall_viol = 0;
    int          fd_cnt = 0;
    int          fd_at = -1;
    logic [21:0] prev_va = '0;
    logic [1:0]  prev_cc = '0;
    logic        cc_run = 1'b0;
    logic        out_ready = 1'b0;
    assign bus.out_ready = out_ready;

    // Inputs change 2 time units after the rising edge; monitors sample on the falling edge.
    initial forever begin
        @(posedge mck);
        #2;
        if (cc_run) clkcnt = clkcnt + 2'd1;
    end

    always @(negedge mck) begin
        if (bus.va !== prev_va) begin
            if (va_log.size() > 0 && prev_cc == 2'd2) stall_viol++;
            va_log.push_back(bus.va);
        end
        prev_va = bus.va;
        prev_cc = clkcnt;
        if (bus.out_valid && bus.out_ready)
            xq.push_back({bus.out_x, bus.out_y, bus.out_wide, bus.out_pix});
        if (bus.frame_done) begin
            fd_cnt++;
            fd_at = xq.size();
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mck);
            #2;
        end
    endtask

    task automatic do_reset();
        lcdon = 1'b0;
        out_ready = 1'b0;
        res = 1'b1;
        step(2);
        res = 1'b0;
        step(1);
        xq.delete();
        va_log.delete();
        stall_viol = 0;
        fd_cnt = 0;
        fd_at = -1;
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int k = 0;
        while (xq.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(xq.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (bus.out_valid !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_cell(input int idx, input string tag, input logic [9:0] x,
                              input logic [5:0] y, input logic wide, input logic [7:0] pix);
        if (idx >= xq.size()) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_x"}, 32'(xq[idx].x), 32'(x));
            check({tag, "_y"}, 32'(xq[idx].y), 32'(y));
            check({tag, "_wide"}, 32'(xq[idx].wide), 32'(wide));
            check({tag, "_pix"}, 32'(xq[idx].pix), 32'(pix));
        end
    endtask

    task automatic check_va_seen(input string tag, input logic [21:0] a);
        logic found = 1'b0;
        foreach (va_log[i]) if (va_log[i] == a) found = 1'b1;
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic check_va_idx(input int idx, input string tag, input logic [21:0] a);
        if (idx >= va_log.size()) check({tag, "_present"}, 32'd0, 32'd1);
        else check(tag, 32'(va_log[idx]), 32'(a));
    endtask

    initial begin
        logic [7:0] grey_exp;
        int         y63;
        lcdon = 1'b0; res = 1'b0;
        pb0w = '0; pb1w = '0; pb2w = '0; pb3w = '0; sbrw = '0;
        t_1s = 1'b1; t_5ms = 1'b0;

        // Reset state
        do_reset();
        check("rst_va", 32'(bus.va), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x", 32'(bus.out_x), 32'd0);
        check("rst_y", 32'(bus.out_y), 32'd0);
        check("rst_wide", 32'(bus.out_wide), 32'd0);
        check("rst_pix", 32'(bus.out_pix), 32'd0);
        check("rst_fd", 32'(bus.frame_done), 32'd0);

        // Run 1: lores row with effects, clkcnt cycling, eight lines
        cc_run = 1'b1;
        sbrw = 11'h001; pb1w = 10'h3F0; pb2w = 9'h005;
        t_1s = 1'b0; t_5ms = 1'b1; out_ready = 1'b1;
        mem.delete();
        mem[32'h800] = 8'h41; mem[32'h801] = 8'h00;
        mem[32'h802] = 8'h42; mem[32'h803] = 8'h10;
        mem[32'h804] = 8'h43; mem[32'h805] = 8'h08;
        mem[32'h806] = 8'h44; mem[32'h807] = 8'h02;
        mem[32'h808] = 8'h45; mem[32'h809] = 8'h04;
        mem[32'h3F020B] = 8'h2A;
        mem[32'h3F0210] = 8'h3F;
        mem[32'h3F0218] = 8'h15;
        mem[32'h3F0220] = 8'h21;
        mem[32'h3F0228] = 8'h33;
        mem_gen++;
        lcdon = 1'b1;
        wait_xfers(856, 9000, "run1_done");
        lcdon = 1'b0;
        step(2);
        check_va_idx(0, "va_attr0", 22'h000800);
        check_va_idx(1, "va_attr1", 22'h000801);
        check_va_idx(2, "va_font0", 22'h3F0208);
        check_va_idx(3, "va_next_attr0", 22'h000802);
        check("no_capture_in_z80", 32'(stall_viol), 32'd0);
        check_va_seen("va_font_lores_y3", 22'h3F020B);
        check_cell(1, "rev", 10'd6, 6'd0, 1'b0, 8'h00);
        check_cell(2, "fls", 10'd12, 6'd0, 1'b0, 8'h00);
        check_cell(3, "und_y0", 10'd18, 6'd0, 1'b0, 8'h84);
`ifdef LCD_GREY_EN
        grey_exp = 8'h00;
`else
        grey_exp = 8'hCC;
`endif
        check_cell(4, "gry", 10'd24, 6'd0, 1'b0, grey_exp);
        check_cell(106, "line0_last", 10'd636, 6'd0, 1'b0, 8'h00);
        check_cell(107, "line1_first", 10'd0, 6'd1, 1'b0, 8'h00);
        check_cell(321, "lores_y3", 10'd0, 6'd3, 1'b0, 8'hA8);
        check_cell(752, "und_y7", 10'd18, 6'd7, 1'b0, 8'hFC);

        // Run 2: hires cell, held off by out_ready=0
        do_reset();
        sbrw = 11'h000; pb1w = 10'h000; pb2w = 9'h005;
        t_1s = 1'b1; t_5ms = 1'b0;
        mem.delete();
        mem[32'h0] = 8'h10; mem[32'h1] = 8'h21;
        mem[32'hA880] = 8'h5A;
        mem_gen++;
        lcdon = 1'b1;
        wait_valid(50, "hires_valid");
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d_pix", i), 32'(bus.out_pix), 32'h5A);
            check($sformatf("hold%0d_x", i), 32'(bus.out_x), 32'd0);
            check($sformatf("hold%0d_wide", i), 32'(bus.out_wide), 32'd1);
        end
        check_va_seen("va_font_hires", 22'h00A880);
        out_ready = 1'b1;
        wait_xfers(2, 50, "run2_two_cells");
        out_ready = 1'b0;
        check_cell(0, "hires", 10'd0, 6'd0, 1'b1, 8'h5A);
        check_cell(1, "after_hires", 10'd8, 6'd0, 1'b0, 8'h40);

        // Run 3: lcdon dropped while a cell is pending
        wait_valid(50, "abort_valid");
        lcdon = 1'b0;
        step(1);
        check("abort_valid_drop", 32'(bus.out_valid), 32'd0);
        step(5);
        check("abort_still_idle", 32'(bus.out_valid), 32'd0);
        check("abort_no_fd", 32'(fd_cnt), 32'd0);
        check("abort_no_xfer", 32'(xq.size()), 32'd2);

        // Run 4: reset during EMIT
        do_reset();
        out_ready = 1'b1;
        lcdon = 1'b1;
        wait_xfers(1, 50, "run4_first");
        out_ready = 1'b0;
        wait_valid(50, "run4_valid");
        check("pre_rst_pix", 32'(bus.out_pix), 32'h40);
        check("pre_rst_x", 32'(bus.out_x), 32'd8);
        res = 1'b1;
        step(1);
        check("emit_rst_va", 32'(bus.va), 32'd0);
        check("emit_rst_valid", 32'(bus.out_valid), 32'd0);
        check("emit_rst_x", 32'(bus.out_x), 32'd0);
        check("emit_rst_pix", 32'(bus.out_pix), 32'd0);
        check("emit_rst_y", 32'(bus.out_y), 32'd0);
        check("emit_rst_wide", 32'(bus.out_wide), 32'd0);
        check("emit_rst_fd", 32'(bus.frame_done), 32'd0);
        res = 1'b0;

        // Run 5: full all-lores frame without Z80 stalls
        do_reset();
        cc_run = 1'b0;
        clkcnt = 2'd0;
        pb2w = 9'h000;
        mem.delete();
        mem_gen++;
        out_ready = 1'b1;
        lcdon = 1'b1;
        begin
            int k = 0;
            while (fd_cnt == 0 && k < 32000) begin
                step(1);
                k++;
            end
        end
        check("frame_done_seen", 32'(fd_cnt > 0), 32'd1);
        step(10);
        check("frame_done_once", 32'(fd_cnt), 32'd1);
        check("frame_cells", 32'(fd_at), 32'd6848);
        y63 = 0;
        foreach (xq[i]) if (i < 6848 && xq[i].y == 6'd63) y63++;
        check("line63_cells", 32'(y63), 32'd107);
        check_cell(6847, "frame_last", 10'd636, 6'd63, 1'b0, 8'h00);
        check_cell(6848, "next_frame_first", 10'd0, 6'd0, 1'b0, 8'h00);
        lcdon = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
